// File: rtl/dwt_poly_mac_pkg.sv
// rtl/dwt_poly_mac_pkg.sv - shared FSM type and width helpers for dwt_poly_mac
//
// Package dwt_pkg. It holds:
//   dwt_state_e : FSM state encoding (IDLE / MAC / HOLD)
//   clog2       : ceiling log2, for sizing counters and indices
//   acc_width   : accumulator width with enough headroom for NTAPS products
package dwt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } dwt_state_e;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A product magnitude never exceeds 2^(w_in+c_in-2). Adding clog2(ntaps)
  // bits of headroom therefore keeps any sum of ntaps products in range.
  function automatic int acc_width(input int w_in, input int c_in, input int ntaps);
    return w_in + c_in + clog2(ntaps);
  endfunction

endpackage

// File: rtl/dwt_poly_mac_if.sv
// rtl/dwt_poly_mac_if.sv - sample/coefficient/output bus of dwt_poly_mac
//
// Signals:
//   in_valid/in_ready/in_data            input sample handshake (signed W_IN)
//   coef_we/coef_addr/coef_wdata         coefficient write port (signed C_IN)
//   out_valid/out_ready/out_data         decimated output handshake (signed Y_OUT)
//   sat_flag                             last output was clipped
// Modports: master = sample source / sink side; slave = the filter block.
interface dwt_poly_mac_if
  import dwt_pkg::*;
#(
  parameter int W_IN  = 7,
  parameter int C_IN  = 5,
  parameter int Y_OUT = 20,
  parameter int NTAPS = 4
) ();

  localparam int AW = clog2(NTAPS);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W_IN-1:0]  in_data;
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [C_IN-1:0]  coef_wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [Y_OUT-1:0] out_data;
  logic                    sat_flag;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, out_ready,
    output in_ready, out_valid, out_data, sat_flag
  );

endinterface

// File: rtl/dwt_poly_mac_coef_rf.sv
// rtl/dwt_poly_mac_coef_rf.sv - NTAPS x C_IN coefficient register file
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset (clears all entries)
//   we_i        write strobe (already qualified by the parent)
//   waddr_i     write index; indices >= NTAPS are dropped
//   wdata_i     signed coefficient
//   raddr_i     combinational read index; indices >= NTAPS read as 0
//   rdata_o     signed coefficient at raddr_i
module dwt_coef_rf #(
  parameter int C_IN  = 5,
  parameter int NTAPS = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   we_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic signed [C_IN-1:0] wdata_i,
  input  logic [AW-1:0]          raddr_i,
  output logic signed [C_IN-1:0] rdata_o
);

  logic signed [C_IN-1:0] mem_q [NTAPS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < NTAPS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < NTAPS) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/dwt_poly_mac.sv
// rtl/dwt_poly_mac.sv - time-multiplexed polyphase FIR phase engine (one MAC)
//
// Ports:
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   bus    dwt_poly_mac_if.slave: sample input, coefficient writes, output
// Every DEC accepted samples one output y = sum c[k]*x[n-k] is produced by
// stepping a single multiplier over the NTAPS taps.
// Build option DWT_MAC_SAT_EN: saturate out_data to Y_OUT bits and report
// clipping on sat_flag; otherwise out_data wraps and sat_flag stays 0.
module dwt_poly_mac
  import dwt_pkg::*;
#(
  parameter int W_IN  = 7,
  parameter int C_IN  = 5,
  parameter int Y_OUT = 20,
  parameter int NTAPS = 4,
  parameter int DEC   = 2
) (
  input logic           clk,
  input logic           rstn,
  dwt_poly_mac_if.slave bus
);

  localparam int AW    = clog2(NTAPS);
  localparam int TW    = clog2(NTAPS + 1);
  localparam int PW    = W_IN + C_IN;
  localparam int ACC_W = acc_width(W_IN, C_IN, NTAPS);
  localparam int PHW   = (DEC > 1) ? clog2(DEC) : 1;

  dwt_state_e              state_q;
  logic signed [W_IN-1:0]  x_q [NTAPS];
  logic [PHW-1:0]          phase_q, phase_d;
  logic [TW-1:0]           tap_q;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    in_ready_q, out_valid_q, sat_q;
  logic signed [Y_OUT-1:0] out_data_q;

  logic                    accept, group_done, coef_we_idle, y_sat;
  logic signed [C_IN-1:0]  coef_rd;
  logic signed [W_IN-1:0]  x_rd;
  logic signed [Y_OUT-1:0] y_red;

  assign accept       = bus.in_valid & in_ready_q;
  // The group closes on the sample that arrives while the phase sits at DEC-1.
  assign group_done   = (phase_q == PHW'(DEC - 1));
  assign phase_d      = group_done ? '0 : phase_q + PHW'(1);
  assign coef_we_idle = bus.coef_we & (state_q == IDLE);

  dwt_coef_rf #(
    .C_IN (C_IN),
    .NTAPS(NTAPS),
    .AW   (AW)
  ) u_coef_rf (
    .clk    (clk),
    .rstn   (rstn),
    .we_i   (coef_we_idle),
    .waddr_i(bus.coef_addr),
    .wdata_i(bus.coef_wdata),
    .raddr_i(tap_q[AW-1:0]),
    .rdata_o(coef_rd)
  );

  // The multiplier output is registered: the tap counter runs one step past
  // NTAPS-1 so that the last product can drain into the final sum.
  assign x_rd   = x_q[tap_q[AW-1:0]];
  assign prod_d = (tap_q < TW'(NTAPS)) ? PW'(coef_rd) * PW'(x_rd) : '0;
  assign acc_d  = acc_q + ACC_W'(prod_q);

  generate
    if (Y_OUT >= ACC_W) begin : g_extend
      assign y_red = Y_OUT'(acc_d);
      assign y_sat = 1'b0;
    end else begin : g_reduce
`ifdef DWT_MAC_SAT_EN
      // The sum fits only when every bit above the kept sign bit copies it.
      logic [ACC_W-Y_OUT:0] top;
      assign top   = acc_d[ACC_W-1:Y_OUT-1];
      assign y_sat = ~(&top | ~|top);
      assign y_red = !y_sat         ? Y_OUT'(acc_d) :
                     acc_d[ACC_W-1] ? {1'b1, {(Y_OUT-1){1'b0}}} :
                                      {1'b0, {(Y_OUT-1){1'b1}}};
`else
      assign y_red = Y_OUT'(acc_d);
      assign y_sat = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      phase_q     <= '0;
      tap_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q[0] <= bus.in_data;
            for (int k = NTAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
            phase_q <= phase_d;
            if (group_done) begin
              state_q    <= MAC;
              in_ready_q <= 1'b0;
              tap_q      <= '0;
              prod_q     <= '0;
              acc_q      <= '0;
            end
          end
        end
        MAC: begin
          prod_q <= prod_d;
          acc_q  <= acc_d;
          tap_q  <= tap_q + TW'(1);
          if (tap_q == TW'(NTAPS)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= y_red;
            sat_q       <= y_sat;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_dwt_poly_mac.sv
// tb/tb_dwt_poly_mac.sv - randomized self-checking bench for dwt_poly_mac
module tb_dwt_poly_mac;

  localparam int W_IN  = 7;
  localparam int C_IN  = 5;
  localparam int NTAPS = 4;
  localparam int YA    = 20;
  localparam int DECA  = 2;
  localparam int YB    = 8;
  localparam int DECB  = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dwt_poly_mac_if #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(YA), .NTAPS(NTAPS)) ia ();
  dwt_poly_mac_if #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(YB), .NTAPS(NTAPS)) ib ();

  dwt_poly_mac #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(YA), .NTAPS(NTAPS), .DEC(DECA))
    u_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
  dwt_poly_mac #(.W_IN(W_IN), .C_IN(C_IN), .Y_OUT(YB), .NTAPS(NTAPS), .DEC(DECB))
    u_b (.clk(clk), .rstn(rstn), .bus(ib.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: full sample history and coefficient values per DUT.
  int hist0[$];
  int hist1[$];
  int cm [2][NTAPS];
  int nacc [2];

  int stall   = 0;
  int poke    = 0;
  int co_addr = -1;
  int co_val  = 0;

  function automatic logic rdy(int d); return (d == 0) ? ia.in_ready : ib.in_ready; endfunction
  function automatic logic ov(int d);  return (d == 0) ? ia.out_valid : ib.out_valid; endfunction
  function automatic logic sf(int d);  return (d == 0) ? ia.sat_flag : ib.sat_flag; endfunction
  function automatic int od(int d);    return (d == 0) ? int'(ia.out_data) : int'(ib.out_data); endfunction
  function automatic int dec_of(int d); return (d == 0) ? DECA : DECB; endfunction

  task automatic drv_in(int d, logic v, int x);
    if (d == 0) begin ia.in_valid = v; ia.in_data = 7'(x); end
    else begin ib.in_valid = v; ib.in_data = 7'(x); end
  endtask

  task automatic drv_coef(int d, logic we, int a, int c);
    if (d == 0) begin ia.coef_we = we; ia.coef_addr = 2'(a); ia.coef_wdata = 5'(c); end
    else begin ib.coef_we = we; ib.coef_addr = 2'(a); ib.coef_wdata = 5'(c); end
  endtask

  task automatic drv_ordy(int d, logic r);
    if (d == 0) ia.out_ready = r; else ib.out_ready = r;
  endtask

  task automatic model_reset();
    hist0.delete();
    hist1.delete();
    for (int d = 0; d < 2; d++) begin
      nacc[d] = 0;
      for (int k = 0; k < NTAPS; k++) cm[d][k] = 0;
    end
  endtask

  // y = sum c[k] * x[n-k], samples before the start of history count as 0.
  function automatic int raw_y(int d);
    int s = 0;
    int n = (d == 0) ? hist0.size() : hist1.size();
    for (int k = 0; k < NTAPS; k++)
      if (n > k) s += cm[d][k] * ((d == 0) ? hist0[n-1-k] : hist1[n-1-k]);
    return s;
  endfunction

  task automatic model_out(int d, output int y, output logic s);
    int v = raw_y(d);
    int half = 1 << (YB - 1);
    y = v;
    s = 1'b0;
    if (d == 1) begin
`ifdef DWT_MAC_SAT_EN
      if (v > half - 1) begin y = half - 1; s = 1'b1; end
      else if (v < -half) begin y = -half; s = 1'b1; end
`else
      y = ((v % (2 * half)) + 2 * half) % (2 * half);
      if (y >= half) y -= 2 * half;
`endif
    end
  endtask

  task automatic write_coef(int d, int a, int c);
    drv_coef(d, 1'b1, a, c);
    @(posedge clk); #1;
    drv_coef(d, 1'b0, 0, 0);
    if (a < NTAPS) cm[d][a] = c;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
  endtask

  // Offers one sample; when it closes a group, checks timing, data and release.
  task automatic accept_sample(int d, int x, bit do_check);
    int n = 0;
    int y;
    logic s;
    int lows = 0;
    int cyc = 0;
    drv_ordy(d, (stall == 0));
    while (rdy(d) !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    n_chk++;
    if (rdy(d) !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_wait dut%0d: in_ready=%b required 1", d, rdy(d));
      return;
    end
    drv_in(d, 1'b1, x);
    if (co_addr >= 0) drv_coef(d, 1'b1, co_addr, co_val);
    @(posedge clk); #1;
    drv_in(d, 1'b0, 0);
    drv_coef(d, 1'b0, 0, 0);
    if (co_addr >= 0 && co_addr < NTAPS) cm[d][co_addr] = co_val;
    co_addr = -1;
    if (d == 0) hist0.push_back(x); else hist1.push_back(x);
    nacc[d]++;
    if (nacc[d] % dec_of(d) != 0) begin
      n_chk++;
      if (rdy(d) !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back dut%0d: in_ready=%b required 1", d, rdy(d));
      end
      return;
    end
    if (!do_check) return;
    model_out(d, y, s);
    while (ov(d) !== 1'b1 && cyc < 20) begin
      if (rdy(d) === 1'b0) lows++;
      if (poke != 0 && cyc == poke) drv_coef(d, 1'b1, 1, 7);
      @(posedge clk); #1;
      cyc++;
      drv_coef(d, 1'b0, 0, 0);
    end
    n_chk++;
    if (cyc != NTAPS + 1) begin
      n_fail++;
      $display("FAIL out_latency dut%0d: %0d cycles required %0d", d, cyc, NTAPS + 1);
    end
    n_chk++;
    if (od(d) != y) begin
      n_fail++;
      $display("FAIL out_data dut%0d: got %0d required %0d", d, od(d), y);
    end
    n_chk++;
    if (sf(d) !== s) begin
      n_fail++;
      $display("FAIL sat_flag dut%0d: got %b required %b", d, sf(d), s);
    end
    for (int i = 0; i < stall; i++) begin
      if (rdy(d) === 1'b0) lows++;
      @(posedge clk); #1;
      n_chk++;
      if (ov(d) !== 1'b1 || od(d) != y || rdy(d) !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable dut%0d: valid=%b data=%0d ready=%b required 1/%0d/0",
                 d, ov(d), od(d), rdy(d), y);
      end
    end
    drv_ordy(d, 1'b1);
    if (rdy(d) === 1'b0) lows++;
    @(posedge clk); #1;
    n_chk++;
    if (ov(d) !== 1'b0 || rdy(d) !== 1'b1 || od(d) != y) begin
      n_fail++;
      $display("FAIL release dut%0d: valid=%b ready=%b data=%0d required 0/1/%0d",
               d, ov(d), rdy(d), od(d), y);
    end
    n_chk++;
    if (lows != NTAPS + 2 + stall) begin
      n_fail++;
      $display("FAIL in_ready_low dut%0d: %0d cycles required %0d", d, lows, NTAPS + 2 + stall);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rdy(d) !== 1'b1 || ov(d) !== 1'b0 || od(d) != 0 || sf(d) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b data=%0d sat=%b required 1/0/0/0",
                 d, rdy(d), ov(d), od(d), sf(d));
      end
    end
    rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rdy(d) !== 1'b1 || ov(d) !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset dut%0d: ready=%b valid=%b required 1/0", d, rdy(d), ov(d));
      end
    end
  endtask

  task automatic test_dec2();
    for (int k = 0; k < NTAPS; k++) write_coef(0, k, k + 1);
    for (int i = 1; i <= 4; i++) begin
      accept_sample(0, i, 1'b1);
      if (i == 2 || i == 4) begin
        n_chk++;
        if (od(0) != ((i == 2) ? 4 : 20)) begin
          n_fail++;
          $display("FAIL dec2_value: got %0d required %0d", od(0), (i == 2) ? 4 : 20);
        end
      end
    end
  endtask

  task automatic test_dec1();
    write_coef(1, 0, 1);
    for (int k = 1; k < NTAPS; k++) write_coef(1, k, 0);
    accept_sample(1, -3, 1'b1);
    n_chk++;
    if (od(1) != -3) begin n_fail++; $display("FAIL dec1_first: got %0d required -3", od(1)); end
    accept_sample(1, 5, 1'b1);
    n_chk++;
    if (od(1) != 5) begin n_fail++; $display("FAIL dec1_second: got %0d required 5", od(1)); end
  endtask

  task automatic test_backpressure();
    stall = 10;
    accept_sample(0, 11, 1'b1);
    accept_sample(0, -7, 1'b1);
    stall = 0;
  endtask

  task automatic test_coef_gate();
    poke = 2;
    accept_sample(0, 9, 1'b1);
    accept_sample(0, -20, 1'b1);
    poke = 0;
    accept_sample(0, 13, 1'b1);
    accept_sample(0, 30, 1'b1);
    write_coef(0, 1, 7);
    accept_sample(0, -1, 1'b1);
    co_addr = 2;
    co_val  = -5;
    accept_sample(0, 17, 1'b1);
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 3; r++) begin
        for (int k = 0; k < NTAPS; k++) write_coef(d, k, int'($urandom_range(0, 31)) - 16);
        for (int i = 0; i < 8; i++) begin
          stall = int'($urandom_range(0, 2));
          if ($urandom_range(0, 3) == 0) begin
            co_addr = int'($urandom_range(0, NTAPS - 1));
            co_val  = int'($urandom_range(0, 31)) - 16;
          end
          accept_sample(d, int'($urandom_range(0, 127)) - 64, 1'b1);
        end
      end
    end
    stall = 0;
  endtask

  task automatic test_sat();
    pulse_reset();
    for (int k = 0; k < NTAPS; k++) write_coef(1, k, -16);
    accept_sample(1, -64, 1'b1);
`ifdef DWT_MAC_SAT_EN
    n_chk++;
    if (od(1) != 127 || sf(1) !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_case: data=%0d sat=%b required 127/1", od(1), sf(1));
    end
`else
    n_chk++;
    if (od(1) != 0 || sf(1) !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_case: data=%0d sat=%b required 0/0", od(1), sf(1));
    end
`endif
  endtask

  task automatic test_abort();
    write_coef(0, 0, 3);
    write_coef(0, 1, -2);
    write_coef(0, 2, 5);
    write_coef(0, 3, 1);
    accept_sample(0, 10, 1'b1);
    accept_sample(0, 20, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (ov(0) !== 1'b0 || rdy(0) !== 1'b1 || od(0) != 0) begin
      n_fail++;
      $display("FAIL abort_state: valid=%b ready=%b data=%0d required 0/1/0", ov(0), rdy(0), od(0));
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    accept_sample(0, 25, 1'b1);
    accept_sample(0, -40, 1'b1);
    n_chk++;
    if (od(0) != 0) begin n_fail++; $display("FAIL abort_zero_coef: got %0d required 0", od(0)); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      drv_in(d, 1'b0, 0);
      drv_coef(d, 1'b0, 0, 0);
      drv_ordy(d, 1'b1);
    end
    rstn = 1'b0;
    model_reset();
    test_reset();
    test_dec2();
    test_dec1();
    test_backpressure();
    test_coef_gate();
    test_random();
    test_sat();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
